// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package cpu_pipe_pkg;

  // Controller states. RUN covers normal flow, branch flush and one-cycle
  // hazard stalls. MEM_WAIT freezes the pipe while data memory is busy.
  // TIMEOUT is a terminal freeze that only reset can leave.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } hz_state_e;

  // XZR reads as zero and writes are discarded, so it never carries a value
  // between instructions.
  localparam logic [4:0] XZR = 5'd31;

  // Default number of MEM_WAIT cycles tolerated before giving up.
  localparam int DEF_MEM_TIMEOUT = 255;

  // True when an ID source register is read and matches a non-XZR EX
  // destination.
  function automatic logic reg_hazard(input logic [4:0] ex_rd,
                                      input logic [4:0] src,
                                      input logic       uses);
    return uses && (src == ex_rd) && (ex_rd != XZR);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: hazard information in, pipeline register controls out.
// Handshake: mem_req is held by the MEM stage until the cycle in which
// mem_ready is high; that cycle completes the access and the pipe moves on.
interface pipeline_hazard_ctrl_if
  import cpu_pipe_pkg::*;
#(
  parameter int STALL_CNT_W = 16
);
  logic [4:0]             id_rn;
  logic [4:0]             id_rm;
  logic                   id_uses_rn;
  logic                   id_uses_rm;
  logic                   id_is_bcond;
  logic                   ex_mem_read;
  logic                   ex_set_flags;
  logic [4:0]             ex_rd;
  logic                   ex_br_taken;
  logic                   mem_req;
  logic                   mem_ready;
  logic                   pc_en;
  logic                   ifid_en;
  logic                   idex_en;
  logic                   exmem_en;
  logic                   memwb_en;
  logic                   ifid_flush;
  logic                   idex_bubble;
  logic                   memwb_bubble;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   mem_timeout;
  hz_state_e              dbg_state;

  // Pipeline side: supplies hazard information, consumes controls.
  modport master (
    output id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_bcond,
           ex_mem_read, ex_set_flags, ex_rd, ex_br_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_bubble, memwb_bubble, stall_cnt, mem_timeout,
           dbg_state
  );

  // Controller side.
  modport slave (
    input  id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_bcond,
           ex_mem_read, ex_set_flags, ex_rd, ex_br_taken, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_bubble, memwb_bubble, stall_cnt, mem_timeout,
           dbg_state
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // Clear has priority; count only while below the saturation value.
  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze, taken-branch
// flush, load-use and flag-use stalls, plus a stall-cycle statistic.
module pipeline_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int STALL_CNT_W = 16,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  bus
);
  localparam int              WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e               r_state;
  hz_state_e               w_state_nxt;
  logic [WAIT_W-1:0]       r_wait_cnt;
  logic                    r_mem_timeout;

  logic                    w_wait_clr;
  logic                    w_wait_inc;
  logic                    w_timeout_set;
  logic                    w_frozen;
  logic                    w_load_use;
  logic                    w_flag_use;
  logic                    w_pc_en;
  logic                    w_ifid_en;
  logic                    w_idex_en;
  logic                    w_exmem_en;
  logic                    w_memwb_en;
  logic                    w_ifid_flush;
  logic                    w_idex_bubble;
  logic                    w_memwb_bubble;
  logic [STALL_CNT_W-1:0]  w_stall_cnt;

  assign w_load_use = bus.ex_mem_read &&
                      (reg_hazard(bus.ex_rd, bus.id_rn, bus.id_uses_rn) ||
                       reg_hazard(bus.ex_rd, bus.id_rm, bus.id_uses_rm));
  assign w_flag_use = bus.id_is_bcond && bus.ex_set_flags;

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wait_clr) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout_set) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  // Next state and pipeline controls, in priority order: memory freeze,
  // taken branch, data/flag hazard, normal run. The cycle in which a memory
  // wait ends re-examines the instructions in ID/EX like any RUN cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_clr     = 1'b0;
    w_wait_inc     = 1'b0;
    w_timeout_set  = 1'b0;
    w_frozen       = 1'b0;
    w_pc_en        = 1'b1;
    w_ifid_en      = 1'b1;
    w_idex_en      = 1'b1;
    w_exmem_en     = 1'b1;
    w_memwb_en     = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_bubble  = 1'b0;
    w_memwb_bubble = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wait_clr  = 1'b1;
          w_frozen    = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_frozen   = 1'b1;
          w_wait_inc = 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt   = ST_TIMEOUT;
            w_timeout_set = 1'b1;
          end
        end
      end
      ST_TIMEOUT: begin
        w_frozen = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_frozen    = 1'b1;
      end
    endcase

    if (w_frozen) begin
      w_pc_en        = 1'b0;
      w_ifid_en      = 1'b0;
      w_idex_en      = 1'b0;
      w_exmem_en     = 1'b0;
      w_memwb_en     = 1'b0;
      w_memwb_bubble = 1'b1;
    end else if (bus.ex_br_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (w_load_use || w_flag_use) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_bubble = 1'b1;
    end

    // In reset everything is held and every stage is filled with NOPs.
    if (!rst) begin
      w_state_nxt    = ST_RUN;
      w_pc_en        = 1'b0;
      w_ifid_en      = 1'b0;
      w_idex_en      = 1'b0;
      w_exmem_en     = 1'b0;
      w_memwb_en     = 1'b0;
      w_ifid_flush   = 1'b1;
      w_idex_bubble  = 1'b1;
      w_memwb_bubble = 1'b1;
    end
  end

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .i_clr_n (rst),
    .i_en    (!w_pc_en),
    .o_cnt   (w_stall_cnt)
  );

  assign bus.pc_en        = w_pc_en;
  assign bus.ifid_en      = w_ifid_en;
  assign bus.idex_en      = w_idex_en;
  assign bus.exmem_en     = w_exmem_en;
  assign bus.memwb_en     = w_memwb_en;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idex_bubble  = w_idex_bubble;
  assign bus.memwb_bubble = w_memwb_bubble;
  assign bus.stall_cnt    = w_stall_cnt;
  assign bus.mem_timeout  = r_mem_timeout;
  assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
  import cpu_pipe_pkg::*;

  localparam int STALL_W  = 4;
  localparam int TIMEOUT  = 8;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.STALL_CNT_W(STALL_W)) bus ();

  pipeline_hazard_ctrl #(
    .STALL_CNT_W (STALL_W),
    .MEM_TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_mode: 0 = running, 1 = waiting on memory, 2 = timed out.
  int m_mode  = 0;
  int m_waits = 0;   // cycles already spent waiting after entering the wait
  int m_stall = 0;
  bit m_tout  = 0;

  // Controls packed as {pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble, memwb_bubble}.
  function automatic logic [7:0] model_ctrl();
    bit hz_rn, hz_rm, load_use, flag_use, mem_hold;
    if (!rst) return 8'b00000_111;
    mem_hold = (m_mode == 2) ||
               (m_mode == 1 && !bus.mem_ready) ||
               (m_mode == 0 && bus.mem_req && !bus.mem_ready);
    if (mem_hold) return 8'b00000_001;
    if (bus.ex_br_taken) return 8'b11111_110;
    hz_rn    = bus.id_uses_rn && (bus.id_rn == bus.ex_rd);
    hz_rm    = bus.id_uses_rm && (bus.id_rm == bus.ex_rd);
    load_use = bus.ex_mem_read && (bus.ex_rd != 5'd31) && (hz_rn || hz_rm);
    flag_use = bus.id_is_bcond && bus.ex_set_flags;
    if (load_use || flag_use) return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  task automatic model_advance(input logic [7:0] ctrl);
    if (!rst) begin
      m_mode = 0; m_waits = 0; m_stall = 0; m_tout = 0;
      return;
    end
    if (!ctrl[7] && m_stall < STALL_MAX) m_stall++;
    if (m_mode == 0) begin
      if (bus.mem_req && !bus.mem_ready) begin
        m_mode = 1; m_waits = 0;
      end
    end else if (m_mode == 1) begin
      if (bus.mem_ready) begin
        m_mode = 0;
      end else begin
        m_waits++;
        if (m_waits == TIMEOUT) begin
          m_mode = 2; m_tout = 1;
        end
      end
    end
  endtask

  function automatic logic [1:0] model_state();
    case (m_mode)
      1:       return ST_MEM_WAIT;
      2:       return ST_TIMEOUT;
      default: return ST_RUN;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.id_rn = 5'd0;  bus.id_rm = 5'd0;
    bus.id_uses_rn = 1'b0; bus.id_uses_rm = 1'b0; bus.id_is_bcond = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_set_flags = 1'b0; bus.ex_rd = 5'd0;
    bus.ex_br_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  task automatic random_inputs();
    bus.id_rn        = rand_reg();
    bus.id_rm        = rand_reg();
    bus.ex_rd        = rand_reg();
    bus.id_uses_rn   = 1'($urandom_range(0, 1));
    bus.id_uses_rm   = 1'($urandom_range(0, 1));
    bus.id_is_bcond  = 1'($urandom_range(0, 1));
    bus.ex_mem_read  = 1'($urandom_range(0, 1));
    bus.ex_set_flags = 1'($urandom_range(0, 1));
    bus.ex_br_taken  = ($urandom_range(0, 5) == 0);
    bus.mem_req      = ($urandom_range(0, 3) == 0);
    bus.mem_ready    = ($urandom_range(0, 2) != 0);
  endtask

  // One clock: check combinational controls and registered outputs mid-cycle,
  // then step the model and return just after the rising edge.
  task automatic cycle(input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    @(negedge clk);
    #1;
    exp_q.push_back(model_ctrl());
    got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
           bus.ifid_flush, bus.idex_bubble, bus.memwb_bubble};
    exp = exp_q.pop_front();
    check_eq({tag, "_ctrl"},  {24'd0, got}, {24'd0, exp});
    check_eq({tag, "_stall"}, {28'd0, bus.stall_cnt}, m_stall);
    check_eq({tag, "_tout"},  {31'd0, bus.mem_timeout}, {31'd0, m_tout});
    check_eq({tag, "_state"}, {30'd0, bus.dbg_state}, {30'd0, model_state()});
    model_advance(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle("rst");
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    clear_inputs();

    // Reset overrides whatever the inputs say.
    random_inputs(); bus.ex_br_taken = 1'b1;
    cycle("reset0");
    random_inputs();
    cycle("reset1");
    rst = 1'b1;
    clear_inputs();
    cycle("idle");
    check_eq("reset_stall_zero", {28'd0, bus.stall_cnt}, 0);

    // Load-use on Rn.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rn = 5'd3; bus.id_uses_rn = 1'b1;
    cycle("load_use");
    clear_inputs();
    check_eq("load_use_stall_one", {28'd0, bus.stall_cnt}, 1);
    cycle("after_lu");

    // XZR destination never stalls.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd31; bus.id_rn = 5'd31; bus.id_uses_rn = 1'b1;
    cycle("xzr");
    check_eq("xzr_stall_kept", {28'd0, bus.stall_cnt}, 1);

    // Load-use via Rm (store data / CBZ operand).
    clear_inputs();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rm = 5'd7; bus.id_uses_rm = 1'b1;
    cycle("load_use_rm");
    check_eq("rm_stall_two", {28'd0, bus.stall_cnt}, 2);

    // Taken branch wins over a concurrent load-use.
    bus.ex_br_taken = 1'b1;
    cycle("br_over_lu");
    check_eq("br_stall_kept", {28'd0, bus.stall_cnt}, 2);

    // Flag hazard, then the same without a flag-setting EX instruction.
    clear_inputs();
    bus.id_is_bcond = 1'b1; bus.ex_set_flags = 1'b1;
    cycle("flag");
    bus.ex_set_flags = 1'b0;
    cycle("no_flag");
    check_eq("flag_stall_three", {28'd0, bus.stall_cnt}, 3);

    // Memory wait of four stalled cycles, then acknowledge.
    clear_inputs();
    do_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle("mem_wait");
    bus.mem_ready = 1'b1;
    cycle("mem_done");
    check_eq("mem_wait_stall_four", {28'd0, bus.stall_cnt}, 4);
    check_eq("mem_back_to_run", {30'd0, bus.dbg_state}, {30'd0, ST_RUN});
    clear_inputs();
    cycle("post_mem");

    // Timeout: entry cycle plus TIMEOUT waiting cycles.
    do_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < TIMEOUT + 1; i++) cycle("to_wait");
    check_eq("timeout_flag_set", {31'd0, bus.mem_timeout}, 1);
    check_eq("timeout_state", {30'd0, bus.dbg_state}, {30'd0, ST_TIMEOUT});
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle("to_hold");
    check_eq("stall_saturated", {28'd0, bus.stall_cnt}, STALL_MAX);
    do_reset();
    check_eq("timeout_cleared", {31'd0, bus.mem_timeout}, 0);
    check_eq("reset_to_run", {30'd0, bus.dbg_state}, {30'd0, ST_RUN});
    clear_inputs();
    cycle("run_again");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      rst = ($urandom_range(0, 59) != 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the stall-cycle counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, MEM_WAIT cycles before timeout error.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 id_rn, id_rm  in  5 each  source registers of the instruction in ID (id_rm also carries the STUR/CBZ Rt).
REQ-006 id_uses_rn, id_uses_rm  in  1 each  ID instruction reads that source.
REQ-007 id_is_bcond  in  1  ID instruction is B.cond (reads flags).
REQ-008 ex_mem_read, ex_set_flags  in  1 each  EX instruction is LDUR / sets flags.
REQ-009 ex_rd  in  5  EX destination register.
REQ-010 ex_br_taken  in  1  branch resolved taken in EX this cycle.
REQ-011 mem_req, mem_ready  in  1 each  MEM-stage data access request / data memory acknowledge.
REQ-012 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register load enables.
REQ-013 ifid_flush, idex_bubble, memwb_bubble  out  1 each  insert NOP into that register.
REQ-014 stall_cnt  out  STALL_CNT_W  saturating count of cycles with pc_en=0.
REQ-015 mem_timeout  out  1  sticky error flag.

Function
REQ-016 FSM states RUN, MEM_WAIT, TIMEOUT; outputs combinational from state and inputs.
REQ-017 Priority, highest first: memory wait, taken branch, load-use/flag stall, normal run.
REQ-018 RUN, mem_req=1 and mem_ready=0: go to MEM_WAIT; this cycle all five enables=0, memwb_bubble=1.
REQ-019 MEM_WAIT: all enables=0, memwb_bubble=1, wait counter increments; on mem_ready=1, return to RUN with normal outputs that cycle.
REQ-020 MEM_WAIT, wait counter reaching MEM_TIMEOUT with mem_ready=0: go to TIMEOUT and set mem_timeout; TIMEOUT holds all enables=0 until reset.
REQ-021 Taken branch (RUN, no memory wait): all enables=1, ifid_flush=1, idex_bubble=1, for exactly that cycle; any concurrent load-use stall is dropped.
REQ-022 Load-use hazard: ex_mem_read=1, ex_rd!=31, and ex_rd equals id_rn with id_uses_rn=1 or id_rm with id_uses_rm=1.
REQ-023 Flag hazard: id_is_bcond=1 and ex_set_flags=1.
REQ-024 On either hazard: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1, memwb_en=1, for one cycle.
REQ-025 Register 31 (XZR) SHALL never create a hazard.
REQ-026 Normal run: all enables=1, all flush/bubble=0.
REQ-027 stall_cnt increments on every cycle with pc_en=0 outside reset, saturating at all-ones without wrapping.
REQ-028 The wait counter clears on every entry to MEM_WAIT.

Reset
REQ-029 While rst=0 at a clock edge: state=RUN, stall_cnt=0, wait counter=0, mem_timeout=0.
REQ-030 While rst=0: all enables=0 and ifid_flush=idex_bubble=memwb_bubble=1, regardless of inputs.
REQ-031 Reset asserted mid-MEM_WAIT or in TIMEOUT SHALL abort to RUN on the next edge, with no residual stall.

Structure
REQ-032 Package cpu_pipe_pkg SHALL hold the FSM state enum, XZR=5'd31 and the default MEM_TIMEOUT.
REQ-033 One sub-module, sat_counter (parameterised width, enable, synchronous active-low clear), SHALL implement stall_cnt.

Verification
REQ-034 ex_mem_read=1, ex_rd=3, id_rn=3, id_uses_rn=1 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt 0->1.
REQ-035 Same as REQ-034 with ex_rd=31 -> no stall, all enables=1.
REQ-036 Load-use hazard and ex_br_taken=1 together -> ifid_flush=1, idex_bubble=1, pc_en=1; stall_cnt unchanged.
REQ-037 mem_req=1, mem_ready low for 4 cycles then high -> 4 cycles all enables=0, memwb_bubble=1, stall_cnt=4, then RUN.
REQ-038 mem_ready held low with MEM_TIMEOUT=8 -> mem_timeout=1 and TIMEOUT after 8 wait cycles; rst=0 for one edge clears the flag and returns to RUN.
REQ-039 id_is_bcond=1, ex_set_flags=1 -> one-cycle stall; with ex_set_flags=0 -> no stall.
